// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared encodings and widths for the I-cache refill path
// Purpose: refill FSM state encodings and line geometry. The Cache imports this
//          package too, so both sides agree on the line width.
// Ports:   none (package).
package icache_refill_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    localparam int LINE_OFFSET_BITS = 4;
    localparam int WORD_SEL_BITS    = 2;
    localparam int CACHE_LINE_W     = 128;

endpackage

// File: rtl/icache_line_buffer.sv
// rtl/icache_line_buffer.sv - refill line buffer, write one word by index, read whole line
// Purpose: collects the memory beats of one cache line.
// Ports:   clk, rst (sync, active-high), we/idx/wdata write one word,
//          line presents all words in parallel (word k at [WORD_W*k +: WORD_W]).
module icache_line_buffer #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [IDX_W-1:0]             idx,
    input  logic [WORD_W-1:0]            wdata,
    output logic [WORD_W*LINE_WORDS-1:0] line
);

    logic [WORD_W-1:0] words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (we) begin
            words[idx] <= wdata;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[i*WORD_W +: WORD_W] = words[i];
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - instruction cache miss handler and line refill controller
// Purpose: on a fetch miss, stalls fetch, reads one line from memory as four
//          beats over a req/valid handshake, then writes it to the Cache with a
//          one-cycle fill_we strobe.
// Ports:   clk, rst (sync, active-high)
//          fetch_valid, fetch_addr, cache_hit  - fetch stage / Cache lookup
//          stall                               - freeze PC and IF/ID
//          mem_req, mem_addr, mem_valid, mem_rdata - memory beat handshake
//          fill_we, address, dataLine          - Cache line write
//          miss_count (only with ICACHE_MISS_CNT_EN defined) - refills started
// Config:  ICACHE_MISS_CNT_EN adds the miss_count output and counter.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    input  logic [ADDR_W-1:0]            fetch_addr,
    input  logic                         cache_hit,
    output logic                         stall,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_valid,
    input  logic [WORD_W-1:0]            mem_rdata,
    output logic                         fill_we,
    output logic [ADDR_W-1:0]            address,
`ifdef ICACHE_MISS_CNT_EN
    output logic [31:0]                  miss_count,
`endif
    output logic [WORD_W*LINE_WORDS-1:0] dataLine
);

    localparam int LINE_W        = WORD_W * LINE_WORDS;
    localparam int BYTE_SEL_BITS = LINE_OFFSET_BITS - WORD_SEL_BITS;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);
    localparam logic [WORD_SEL_BITS-1:0] LAST_BEAT = WORD_SEL_BITS'(LINE_WORDS - 1);

    logic [1:0]               state;
    logic [WORD_SEL_BITS-1:0] beat;
    logic [ADDR_W-1:0]        base;
    logic [ADDR_W-1:0]        address_q;
    logic [LINE_W-1:0]        line_q;
    logic [LINE_W-1:0]        line_buf;
    logic                     miss;
    logic                     beat_done;

    assign miss      = fetch_valid & ~cache_hit;
    assign beat_done = (state == ST_FETCH) & mem_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            base      <= '0;
            address_q <= '0;
            line_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        base  <= fetch_addr & ~OFFSET_MASK;
                        beat  <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_valid) begin
                        if (beat == LAST_BEAT) begin
                            state <= ST_FILL;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    // Capture what the Cache was handed so the outputs hold
                    // steady while the buffer is reused by the next refill.
                    address_q <= base;
                    line_q    <= line_buf;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    icache_line_buffer #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (WORD_SEL_BITS)
    ) u_line_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (beat_done),
        .idx   (beat),
        .wdata (mem_rdata),
        .line  (line_buf)
    );

    assign mem_req  = (state == ST_FETCH);
    // base has a zero line offset, so OR-ing the word index is base + 4*beat
    // and can never carry out of the line.
    assign mem_addr = mem_req ? (base | (ADDR_W'(beat) << BYTE_SEL_BITS)) : '0;
    assign fill_we  = (state == ST_FILL);
    assign address  = fill_we ? base : address_q;
    assign dataLine = fill_we ? line_buf : line_q;
    assign stall    = (state != ST_IDLE) | miss;

`ifdef ICACHE_MISS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count <= '0;
        end else if ((state == ST_IDLE) && miss) begin
            miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_valid;
    logic [31:0]  fetch_addr;
    logic         cache_hit;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic [31:0]  mem_rdata;
    logic         fill_we;
    logic [31:0]  address;
    logic [127:0] dataLine;
`ifdef ICACHE_MISS_CNT_EN
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int failures = 0;
    int exp_misses = 0;

    typedef struct {
        int           fill_count;
        int           fill_cycle;
        int           exp_fill_cycle;
        int           addr_err;
        int           req_cycles;
        int           exp_req_cycles;
        bit           miss_stall;
        bit           stall_after;
        bit           timeout;
        logic [31:0]  fill_addr;
        logic [31:0]  addr_after;
        logic [127:0] fill_line;
        logic [127:0] line_after;
        logic [127:0] exp_line;
    } obs_t;

    icache_refill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .cache_hit   (cache_hit),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .fill_we     (fill_we),
        .address     (address),
`ifdef ICACHE_MISS_CNT_EN
        .miss_count  (miss_count),
`endif
        .dataLine    (dataLine)
    );

    always #5 clk = ~clk;

    // Drives one complete miss and records what the DUT did. The expected
    // values come from the protocol rules: beat k lives at line_base + 4k,
    // memory answers after d[k] idle cycles, the line holds the words in
    // completion order, and the fill lands one cycle after the last beat.
    task automatic do_refill(input logic [31:0] pc, input int dmin, input int dmax,
                             input bit move_pc, input bit seq_data, output obs_t o);
        int d[4];
        int k, w, cyc;
        logic [31:0] base, rd;
        o = '{default: 0};
        base = {pc[31:4], 4'b0000};
        o.exp_req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom_range(dmax, dmin);
            o.exp_req_cycles += d[i] + 1;
        end
        o.exp_fill_cycle = 1 + o.exp_req_cycles + 1;
        exp_misses++;
        @(negedge clk);
        fetch_valid = 1'b1; fetch_addr = pc; cache_hit = 1'b0;
        mem_valid = 1'($urandom); mem_rdata = $urandom;
        #1;
        o.miss_stall = stall;
        if (mem_req) o.addr_err++;
        k = 0; w = 0; cyc = 1;
        while (o.fill_count == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (move_pc) fetch_addr = $urandom;
            rd = (seq_data && k < 4) ? 32'hA + 32'(k) : $urandom;
            mem_rdata = rd;
            mem_valid = (k < 4) ? (w == d[k]) : 1'($urandom);
            #1;
            if (mem_req) begin
                o.req_cycles++;
                if (k >= 4 || mem_addr !== base + 32'(4 * k)) o.addr_err++;
            end
            if (k < 4) begin
                if (mem_valid) begin
                    o.exp_line[32*k +: 32] = rd;
                    k++; w = 0;
                end else begin
                    w++;
                end
            end
            if (fill_we) begin
                o.fill_count++;
                o.fill_cycle = cyc;
                o.fill_addr = address;
                o.fill_line = dataLine;
                cache_hit = 1'b1;
            end
        end
        if (o.fill_count == 0) o.timeout = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0; cache_hit = 1'b1;
        #1;
        o.stall_after = stall;
        o.addr_after = address;
        o.line_after = dataLine;
        if (fill_we) o.fill_count++;
        if (mem_req) o.addr_err++;
        @(negedge clk);
        fetch_valid = 1'b0; cache_hit = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        rst = 1'b1; fetch_valid = 1'b0; cache_hit = 1'b0; fetch_addr = $urandom;
        mem_valid = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        #1;
        exp_misses = 0;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (fill_we !== 1'b0) begin failures++; $display("FAIL reset_fill_we got=%b exp=0", fill_we); end
        checks++; if (address !== 32'h0) begin failures++; $display("FAIL reset_address got=%h exp=0", address); end
        checks++; if (dataLine !== 128'h0) begin failures++; $display("FAIL reset_dataLine got=%h exp=0", dataLine); end
`ifdef ICACHE_MISS_CNT_EN
        checks++; if (miss_count !== 32'h0) begin failures++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
`endif
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            mem_valid = 1'b1; mem_rdata = $urandom;
            #1;
            if (mem_req !== 1'b0 || fill_we !== 1'b0 || stall !== 1'b0) bad++;
        end
        mem_valid = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL idle_ignores_mem_valid bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_basic_miss();
        obs_t o;
        do_refill(32'h0000_005C, 0, 0, 1'b0, 1'b1, o);
        checks++; if (o.miss_stall !== 1'b1) begin failures++; $display("FAIL basic_miss_stall got=%b exp=1", o.miss_stall); end
        checks++; if (o.timeout) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (o.fill_count != 1) begin failures++; $display("FAIL basic_fill_count got=%0d exp=1", o.fill_count); end
        checks++; if (o.fill_cycle != 6) begin failures++; $display("FAIL basic_fill_cycle got=%0d exp=6", o.fill_cycle); end
        checks++; if (o.fill_addr !== 32'h50) begin failures++; $display("FAIL basic_address got=%h exp=00000050", o.fill_addr); end
        checks++; if (o.fill_line !== 128'h0000000D_0000000C_0000000B_0000000A) begin
            failures++; $display("FAIL basic_dataLine got=%h exp=0000000d0000000c0000000b0000000a", o.fill_line); end
        checks++; if (o.addr_err != 0 || o.req_cycles != 4) begin
            failures++; $display("FAIL basic_mem_addr errors=%0d req_cycles=%0d exp=0/4", o.addr_err, o.req_cycles); end
        checks++; if (o.stall_after !== 1'b0) begin failures++; $display("FAIL basic_stall_after_fill got=%b exp=0", o.stall_after); end
        checks++; if (o.addr_after !== 32'h50 || o.line_after !== o.exp_line) begin
            failures++; $display("FAIL basic_hold addr=%h line=%h exp=00000050/%h", o.addr_after, o.line_after, o.exp_line); end
    endtask

    task automatic test_delayed_beats();
        obs_t o;
        do_refill(32'h0000_005C, 3, 3, 1'b0, 1'b0, o);
        checks++; if (o.timeout || o.fill_count != 1) begin
            failures++; $display("FAIL delayed_fill_count got=%0d exp=1 timeout=%b", o.fill_count, o.timeout); end
        checks++; if (o.addr_err != 0 || o.req_cycles != 16) begin
            failures++; $display("FAIL delayed_req_held errors=%0d req_cycles=%0d exp=0/16", o.addr_err, o.req_cycles); end
        checks++; if (o.fill_cycle != 18) begin failures++; $display("FAIL delayed_fill_cycle got=%0d exp=18", o.fill_cycle); end
        checks++; if (o.fill_addr !== 32'h50 || o.fill_line !== o.exp_line) begin
            failures++; $display("FAIL delayed_line addr=%h line=%h exp=00000050/%h", o.fill_addr, o.fill_line, o.exp_line); end
`ifdef ICACHE_MISS_CNT_EN
        checks++; if (miss_count !== 32'd2) begin failures++; $display("FAIL miss_count_after_two got=%0d exp=2", miss_count); end
`endif
    endtask

    task automatic test_pc_change();
        obs_t o;
        do_refill(32'h0000_005C, 0, 2, 1'b1, 1'b0, o);
        checks++; if (o.timeout || o.fill_count != 1) begin
            failures++; $display("FAIL pcmove_fill_count got=%0d exp=1 timeout=%b", o.fill_count, o.timeout); end
        checks++; if (o.addr_err != 0 || o.req_cycles != o.exp_req_cycles) begin
            failures++; $display("FAIL pcmove_beats errors=%0d req_cycles=%0d exp=0/%0d", o.addr_err, o.req_cycles, o.exp_req_cycles); end
        checks++; if (o.fill_addr !== 32'h50 || o.fill_line !== o.exp_line) begin
            failures++; $display("FAIL pcmove_line addr=%h line=%h exp=00000050/%h", o.fill_addr, o.fill_line, o.exp_line); end
    endtask

    task automatic test_reset_mid_refill();
        obs_t o;
        int seen;
        @(negedge clk);
        fetch_valid = 1'b1; fetch_addr = 32'h0000_0124; cache_hit = 1'b0; mem_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mem_valid = 1'b1; mem_rdata = $urandom;
        end
        @(negedge clk);
        rst = 1'b1; mem_valid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0; fetch_valid = 1'b0;
        exp_misses = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle mem_req=%b stall=%b exp=0/0", mem_req, stall); end
        checks++; if (address !== 32'h0 || dataLine !== 128'h0) begin
            failures++; $display("FAIL rstmid_outputs address=%h dataLine=%h exp=0/0", address, dataLine); end
`ifdef ICACHE_MISS_CNT_EN
        checks++; if (miss_count !== 32'h0) begin failures++; $display("FAIL rstmid_miss_count got=%0d exp=0", miss_count); end
`endif
        seen = (fill_we === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            mem_valid = 1'b1;
            #1;
            if (fill_we !== 1'b0) seen++;
        end
        mem_valid = 1'b0;
        checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_fill got=%0d exp=0", seen); end
        do_refill(32'h0000_007C, 0, 1, 1'b0, 1'b0, o);
        checks++; if (o.timeout || o.fill_count != 1 || o.addr_err != 0) begin
            failures++; $display("FAIL rstmid_new_miss fills=%0d addr_errors=%0d exp=1/0", o.fill_count, o.addr_err); end
        checks++; if (o.fill_addr !== 32'h70 || o.fill_line !== o.exp_line) begin
            failures++; $display("FAIL rstmid_new_line addr=%h line=%h exp=00000070/%h", o.fill_addr, o.fill_line, o.exp_line); end
    endtask

    task automatic test_no_miss();
        int bad_stall, bad_req;
        bad_stall = 0; bad_req = 0;
        repeat (40) begin
            @(negedge clk);
            fetch_valid = 1'($urandom);
            cache_hit = fetch_valid ? 1'b1 : 1'($urandom);
            fetch_addr = $urandom; mem_valid = 1'($urandom); mem_rdata = $urandom;
            #1;
            if (stall !== 1'b0) bad_stall++;
            if (mem_req !== 1'b0 || fill_we !== 1'b0) bad_req++;
        end
        fetch_valid = 1'b0; cache_hit = 1'b0; mem_valid = 1'b0;
        checks++; if (bad_stall != 0) begin failures++; $display("FAIL nomiss_stall bad_cycles=%0d exp=0", bad_stall); end
        checks++; if (bad_req != 0) begin failures++; $display("FAIL nomiss_mem_req bad_cycles=%0d exp=0", bad_req); end
    endtask

    task automatic test_random_refills();
        obs_t o;
        logic [31:0] pc;
        repeat (8) begin
            pc = $urandom;
            do_refill(pc, 0, 4, 1'($urandom), 1'b0, o);
            checks++; if (o.timeout || o.fill_count != 1 || o.fill_cycle != o.exp_fill_cycle) begin
                failures++; $display("FAIL rand_fill pc=%h fills=%0d cycle=%0d exp=1/%0d", pc, o.fill_count, o.fill_cycle, o.exp_fill_cycle); end
            checks++; if (o.addr_err != 0 || o.req_cycles != o.exp_req_cycles) begin
                failures++; $display("FAIL rand_beats pc=%h errors=%0d req_cycles=%0d exp=0/%0d", pc, o.addr_err, o.req_cycles, o.exp_req_cycles); end
            checks++; if (o.fill_addr !== {pc[31:4], 4'b0000} || o.fill_line !== o.exp_line) begin
                failures++; $display("FAIL rand_line pc=%h addr=%h line=%h exp_line=%h", pc, o.fill_addr, o.fill_line, o.exp_line); end
            checks++; if (o.line_after !== o.exp_line || o.miss_stall !== 1'b1 || o.stall_after !== 1'b0) begin
                failures++; $display("FAIL rand_hold_stall pc=%h line_after=%h miss_stall=%b stall_after=%b", pc, o.line_after, o.miss_stall, o.stall_after); end
        end
`ifdef ICACHE_MISS_CNT_EN
        checks++; if (miss_count !== 32'(exp_misses)) begin
            failures++; $display("FAIL rand_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
`endif
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; cache_hit = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0;
        test_reset();
        test_basic_miss();
        test_delayed_beats();
        test_pc_change();
        test_reset_mid_refill();
        test_no_miss();
        test_random_refills();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
